pixel_quant_pipe: RTL and testbench
===================================

# pixel_quant_pipe

Parametrised, pipelined pixel normalise-and-quantise stage for the AlexNet input path. Accepts an unsigned channel-interleaved pixel stream and applies per-channel mean subtraction, fixed-point scaling, rounding, zero-point offset and saturation. Emits signed OUT_W-bit activations for the first convolution layer. Adds valid/ready back-pressure, per-channel runtime configuration with frame-aligned update, and saturation statistics.

## Interface
- IN_W, 8, input pixel width (unsigned)
- OUT_W, 8, output activation width (signed two's complement)
- CH, 3, interleaved channels per pixel (1..16)
- SCALE_W, 16, signed scale width
- FRAC_W, 14, fractional bits of scale (1 <= FRAC_W < SCALE_W)
- CHW = max(1, clog2(CH)), derived, channel index width
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_data  in  IN_W  unsigned pixel sample
- in_valid / in_ready  in / out  1  input handshake
- in_sof  in  1  start of frame, qualified by an accepted beat
- out_data  out  OUT_W  signed quantised sample
- out_ch  out  CHW  channel index of out_data
- out_sof  out  1  SOF flag delayed with its beat
- out_valid / out_ready  out / in  1  output handshake
- cfg_we  in  1  write shadow registers of channel cfg_ch
- cfg_ch  in  CHW  target channel; writes with cfg_ch >= CH are ignored
- cfg_mean  in  IN_W  unsigned mean
- cfg_scale  in  SCALE_W  signed Q(SCALE_W-FRAC_W).FRAC_W scale
- cfg_zp  in  OUT_W  signed zero point
- sat_clr  in  1  clear sat_cnt
- sat_cnt  out  16  saturating count of clipped output beats

## Operation
- Beat accepted when in_valid && in_ready.
- Channel counter: accepted beat with in_sof takes channel 0, counter becomes 1 (0 if CH==1). Otherwise the beat takes the counter value, and the counter increments and wraps CH-1 -> 0.
- Config: cfg_we writes shadow[cfg_ch]. Active set copied from shadow on an accepted in_sof beat, and that beat already uses the new values. Shadow write and sof copy in the same cycle: the copy takes the shadow value before the write.
- Stage 1: d = in_data - mean[ch], signed IN_W+1 bits.
- Stage 2: p = d * scale[ch], signed IN_W+1+SCALE_W bits, exact.
- Stage 3: r = (p + 2^(FRAC_W-1)) >>> FRAC_W (arithmetic shift, round half toward +inf). q = r + zp, computed at full width. Clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- If clipping occurred on a beat transferred out, sat_cnt increments, saturating at 0xFFFF.
- sat_clr has priority over increment.
- ch and sof travel with data through all stages.

## Timing
- Reset values: out_valid 0, out_data 0, out_ch 0, out_sof 0, sat_cnt 0, all internal stage valids 0, channel counter 0. Active and shadow sets: mean 0, scale 2^FRAC_W (1.0), zp 0.
- Latency: 3 cycles from acceptance edge to out_valid, with no stall.
- Throughput: 1 beat/cycle.
- Global stall: en = !out_valid || out_ready. in_ready = en, combinational from out_valid/out_ready. All stages advance only when en. Bubbles are not collapsed.
- out_data, out_ch and out_sof hold stable while out_valid && !out_ready.
- Reset asserted mid-stream: pipeline contents discarded and config returns to defaults asynchronously; out_valid low immediately.
- in_data must not be sampled when the beat is not accepted. Counter and config copy act only on accepted beats.

## Test plan
Defaults for all scenarios: IN_W=8, OUT_W=8, CH=3, SCALE_W=16, FRAC_W=14.
- Identity config (mean 0, scale 16384, zp 0): inputs 100, 127, 200 -> outputs 100, 127, 127; sat_cnt=1; first out_valid 3 cycles after first accept.
- Normalise (mean 128, scale 8192, zp 0), applied via sof: inputs 255, 0, 129 -> outputs 64, -64, 1 (0.5 rounds up).
- Zero point and low clip (ch0: mean 0, scale 16384, zp -128; ch1: mean 255, scale 32767, zp 0): 0 on ch0 -> -128, 10 on ch0 -> -118, 0 on ch1 -> -128 with sat_cnt +1. sat_clr then reads 0.
- Back-pressure: 10 random beats, out_ready low for 4 cycles mid-stream -> exact in-order sequence with no loss or duplication; in_ready low while out_valid && !out_ready; outputs stable during the stall.
- Channel and sof: 7 beats with in_sof on beats 0 and 4 -> out_ch 0,1,2,0,0,1,2; out_sof on beats 0 and 4 only.
- Shadow update and reset: write ch1 scale 8192 mid-frame -> ch1 outputs unchanged until the next sof beat, then halved. Assert rstn low during a burst -> out_valid 0 at once, sat_cnt 0, scale back to 16384.

Source files
------------

// File: rtl/pixel_quant_pipe.sv
// pixel_quant_pipe: per-channel mean subtract, fixed-point scale, round,
// zero-point offset and saturate for an interleaved unsigned pixel stream.
// Four register stages (diff, product, offset sum, clipped output) under a
// single global stall; every stage carries its channel index and SOF flag.
module pixel_quant_pipe #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8,
    parameter int CH      = 3,
    parameter int SCALE_W = 16,
    parameter int FRAC_W  = 14,
    parameter int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    output logic [OUT_W-1:0]          out_data,
    output logic [CHW-1:0]            out_ch,
    output logic                      out_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      cfg_we,
    input  logic [CHW-1:0]            cfg_ch,
    input  logic [IN_W-1:0]           cfg_mean,
    input  logic [SCALE_W-1:0]        cfg_scale,
    input  logic [OUT_W-1:0]          cfg_zp,
    input  logic                      sat_clr,
    output logic [15:0]               sat_cnt
);

    localparam int DW = IN_W + 1;        // mean-subtracted sample
    localparam int PW = DW + SCALE_W;    // exact product
    localparam int RW = PW + 1;          // product plus rounding half, no overflow
    localparam int QW = PW + 2;          // rounded value plus zero point

    localparam logic [SCALE_W-1:0]  SCALE_ONE = SCALE_W'(1) << FRAC_W;
    localparam logic [CHW-1:0]      CH_LAST   = CHW'(CH - 1);
    localparam logic [CHW:0]        CH_NUM    = (CHW + 1)'(CH);
    localparam logic signed [RW-1:0] HALF     = RW'(1) << (FRAC_W - 1);

    logic                        w_en;
    logic                        w_acc;
    logic                        w_sof_acc;
    logic                        w_cfg_hit;
    logic [CHW-1:0]              w_ch;
    logic [IN_W-1:0]             w_mean;
    logic signed [SCALE_W-1:0]   w_scale;
    logic signed [OUT_W-1:0]     w_zp;
    logic signed [DW-1:0]        w_d;
    logic signed [PW-1:0]        w_p;
    logic signed [RW-1:0]        w_pr;
    logic signed [RW-1:0]        w_r;
    logic signed [QW-1:0]        w_q;
    logic                        w_hi_ones;
    logic                        w_hi_zeros;
    logic                        w_clip;
    logic [OUT_W-1:0]            w_sat;

    logic [CHW-1:0]              r_ch_cnt;
    logic [IN_W-1:0]             r_sh_mean  [CH];
    logic [SCALE_W-1:0]          r_sh_scale [CH];
    logic [OUT_W-1:0]            r_sh_zp    [CH];
    logic [IN_W-1:0]             r_act_mean [CH];
    logic [SCALE_W-1:0]          r_act_scale[CH];
    logic [OUT_W-1:0]            r_act_zp   [CH];

    logic                        r_s1_vld, r_s2_vld, r_s3_vld;
    logic [CHW-1:0]              r_s1_ch, r_s2_ch, r_s3_ch;
    logic                        r_s1_sof, r_s2_sof, r_s3_sof;
    logic signed [DW-1:0]        r_s1_d;
    logic signed [SCALE_W-1:0]   r_s1_scale;
    logic signed [OUT_W-1:0]     r_s1_zp, r_s2_zp;
    logic signed [PW-1:0]        r_s2_p;
    logic signed [QW-1:0]        r_s3_q;

    logic                        r_out_vld;
    logic [OUT_W-1:0]            r_out_data;
    logic [CHW-1:0]              r_out_ch;
    logic                        r_out_sof;
    logic                        r_out_clip;
    logic [15:0]                 r_sat_cnt;

    assign w_en      = !r_out_vld || out_ready;
    assign w_acc     = in_valid && w_en;
    assign w_sof_acc = w_acc && in_sof;
    assign w_cfg_hit = cfg_we && ({1'b0, cfg_ch} < CH_NUM);

    // Channel select and coefficient lookup; an SOF beat bypasses to the shadow set
    // because the active set is only being loaded on that same edge.
    always_comb begin
        w_ch    = in_sof ? '0 : r_ch_cnt;
        w_mean  = in_sof ? r_sh_mean[0]           : r_act_mean[w_ch];
        w_scale = in_sof ? $signed(r_sh_scale[0]) : $signed(r_act_scale[w_ch]);
        w_zp    = in_sof ? $signed(r_sh_zp[0])    : $signed(r_act_zp[w_ch]);
        w_d     = $signed({1'b0, in_data}) - $signed({1'b0, w_mean});
    end

    // Channel counter: SOF restarts at channel 0, otherwise wrap at CH-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ch_cnt <= '0;
        end else if (w_acc) begin
            if (in_sof || (r_ch_cnt == CH_LAST)) begin
                r_ch_cnt <= (CH == 1) ? '0 : CHW'(1) & {CHW{in_sof}};
            end else begin
                r_ch_cnt <= r_ch_cnt + 1'b1;
            end
        end
    end

    // Shadow writes and frame-aligned copy to the active set (copy sees pre-write shadow).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CH; i++) begin
                r_sh_mean[i]   <= '0;
                r_sh_scale[i]  <= SCALE_ONE;
                r_sh_zp[i]     <= '0;
                r_act_mean[i]  <= '0;
                r_act_scale[i] <= SCALE_ONE;
                r_act_zp[i]    <= '0;
            end
        end else begin
            if (w_cfg_hit) begin
                r_sh_mean[cfg_ch]  <= cfg_mean;
                r_sh_scale[cfg_ch] <= cfg_scale;
                r_sh_zp[cfg_ch]    <= cfg_zp;
            end
            if (w_sof_acc) begin
                for (int i = 0; i < CH; i++) begin
                    r_act_mean[i]  <= r_sh_mean[i];
                    r_act_scale[i] <= r_sh_scale[i];
                    r_act_zp[i]    <= r_sh_zp[i];
                end
            end
        end
    end

    // Stage 1: mean subtraction; the input is only captured on an accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld   <= 1'b0;
            r_s1_d     <= '0;
            r_s1_scale <= '0;
            r_s1_zp    <= '0;
            r_s1_ch    <= '0;
            r_s1_sof   <= 1'b0;
        end else if (w_en) begin
            r_s1_vld <= in_valid;
            if (w_acc) begin
                r_s1_d     <= w_d;
                r_s1_scale <= w_scale;
                r_s1_zp    <= w_zp;
                r_s1_ch    <= w_ch;
                r_s1_sof   <= in_sof;
            end
        end
    end

    assign w_p = PW'(r_s1_d) * PW'(r_s1_scale);

    // Stage 2: exact signed product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_vld <= 1'b0;
            r_s2_p   <= '0;
            r_s2_zp  <= '0;
            r_s2_ch  <= '0;
            r_s2_sof <= 1'b0;
        end else if (w_en) begin
            r_s2_vld <= r_s1_vld;
            r_s2_p   <= w_p;
            r_s2_zp  <= r_s1_zp;
            r_s2_ch  <= r_s1_ch;
            r_s2_sof <= r_s1_sof;
        end
    end

    // Round half toward +inf by adding one half LSB then flooring via arithmetic shift.
    always_comb begin
        w_pr = RW'(r_s2_p) + HALF;
        w_r  = w_pr >>> FRAC_W;
        w_q  = QW'(w_r) + QW'(r_s2_zp);
    end

    // Stage 3: rounded value with zero point, kept at full width until the clip.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s3_vld <= 1'b0;
            r_s3_q   <= '0;
            r_s3_ch  <= '0;
            r_s3_sof <= 1'b0;
        end else if (w_en) begin
            r_s3_vld <= r_s2_vld;
            r_s3_q   <= w_q;
            r_s3_ch  <= r_s2_ch;
            r_s3_sof <= r_s2_sof;
        end
    end

    // In range iff all bits from the OUT_W sign bit upward agree.
    always_comb begin
        w_hi_ones  = &r_s3_q[QW-1:OUT_W-1];
        w_hi_zeros = ~|r_s3_q[QW-1:OUT_W-1];
        w_clip     = !(w_hi_ones || w_hi_zeros);
        w_sat      = w_clip ? {r_s3_q[QW-1], {(OUT_W-1){~r_s3_q[QW-1]}}}
                            : r_s3_q[OUT_W-1:0];
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_out_sof  <= 1'b0;
            r_out_clip <= 1'b0;
        end else if (w_en) begin
            r_out_vld  <= r_s3_vld;
            r_out_data <= w_sat;
            r_out_ch   <= r_s3_ch;
            r_out_sof  <= r_s3_sof;
            r_out_clip <= w_clip;
        end
    end

    // Saturating count of clipped beats actually transferred; clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_out_vld && out_ready && r_out_clip && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_sof   = r_out_sof;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_pixel_quant_pipe.sv
// Directed bench for pixel_quant_pipe with hand-computed expectations.
module tb_pixel_quant_pipe;

    typedef struct packed {
        logic       sof;
        logic [1:0] ch;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_sof;
    logic        out_valid;
    logic        out_ready;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_mean;
    logic [15:0] cfg_scale;
    logic [7:0]  cfg_zp;
    logic        sat_clr;
    logic [15:0] sat_cnt;

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t got_q[$];
    beat_t exp_q[$];
    int    bp_data[10];
    logic [7:0] snap_data;
    logic [1:0] snap_ch;

    pixel_quant_pipe #(
        .IN_W(8), .OUT_W(8), .CH(3), .SCALE_W(16), .FRAC_W(14)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .out_data(out_data), .out_ch(out_ch), .out_sof(out_sof),
        .out_valid(out_valid), .out_ready(out_ready),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean),
        .cfg_scale(cfg_scale), .cfg_zp(cfg_zp),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    // Record every beat that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready)
            got_q.push_back('{sof: out_sof, ch: out_ch, data: out_data});
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send(input int d, input logic s);
        bit ok = 0;
        in_data  = 8'(d);
        in_sof   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int mean, input int scale, input int zp);
        cfg_ch    = 2'(ch);
        cfg_mean  = 8'(mean);
        cfg_scale = 16'(scale);
        cfg_zp    = 8'(zp);
        cfg_we    = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic push_exp(input int d, input int ch, input int s);
        exp_q.push_back('{sof: 1'(s), ch: 2'(ch), data: 8'(d)});
    endtask

    task automatic check_all(input string tag);
        int budget = 0;
        while (got_q.size() < exp_q.size() && budget < 60) begin
            @(posedge clk);
            #1;
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), int'($signed(got_q[i].data)), int'($signed(exp_q[i].data)));
            chk($sformatf("%s_ch%0d", tag, i), int'(got_q[i].ch), int'(exp_q[i].ch));
            chk($sformatf("%s_sof%0d", tag, i), int'(got_q[i].sof), int'(exp_q[i].sof));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; in_data = '0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mean = '0; cfg_scale = '0; cfg_zp = '0; sat_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_sof", int'(out_sof), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Latency: single beat, out_valid appears three edges after acceptance.
        send(100, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_cycle2_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_cycle3_valid", int'(out_valid), 1);
        chk("lat_cycle3_data", int'(out_data), 100);
        push_exp(100, 0, 1);
        check_all("lat");

        // Identity with high clip.
        send(100, 1'b1); send(127, 1'b0); send(200, 1'b0);
        push_exp(100, 0, 1); push_exp(127, 1, 0); push_exp(127, 2, 0);
        check_all("ident");
        chk("ident_sat_cnt", int'(sat_cnt), 1);

        // Normalise, applied through SOF.
        for (int c = 0; c < 3; c++) cfg_write(c, 128, 8192, 0);
        send(255, 1'b1); send(0, 1'b0); send(129, 1'b0);
        push_exp(64, 0, 1); push_exp(-64, 1, 0); push_exp(1, 2, 0);
        check_all("norm");

        // Zero point and low clip.
        cfg_write(0, 0, 16384, -128);
        cfg_write(1, 255, 32767, 0);
        send(0, 1'b1); send(10, 1'b1); send(0, 1'b0);
        push_exp(-128, 0, 1); push_exp(-118, 0, 1); push_exp(-128, 1, 0);
        check_all("zp");
        chk("zp_sat_cnt", int'(sat_cnt), 2);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("sat_clr", int'(sat_cnt), 0);

        // Back-pressure with a 4-cycle consumer stall mid-stream.
        for (int c = 0; c < 3; c++) cfg_write(c, 0, 16384, 0);
        for (int i = 0; i < 10; i++) begin
            bp_data[i] = int'($urandom_range(0, 127));
            push_exp(bp_data[i], i % 3, (i == 0) ? 1 : 0);
        end
        fork
            begin
                for (int i = 0; i < 10; i++) send(bp_data[i], (i == 0) ? 1'b1 : 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                snap_data = out_data;
                snap_ch   = out_ch;
                chk("bp_stall_valid", int'(out_valid), 1);
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #2;
                    chk($sformatf("bp_in_ready%0d", k), int'(in_ready), 0);
                    chk($sformatf("bp_hold_data%0d", k), int'(out_data), int'(snap_data));
                    chk($sformatf("bp_hold_ch%0d", k), int'(out_ch), int'(snap_ch));
                end
                out_ready = 1'b1;
            end
        join
        check_all("bp");

        // Channel index and SOF realignment.
        for (int i = 0; i < 7; i++) send(10 + i, (i == 0 || i == 4) ? 1'b1 : 1'b0);
        push_exp(10, 0, 1); push_exp(11, 1, 0); push_exp(12, 2, 0); push_exp(13, 0, 0);
        push_exp(14, 0, 1); push_exp(15, 1, 0); push_exp(16, 2, 0);
        check_all("chsof");

        // Shadow write mid-frame takes effect only at the next SOF.
        send(20, 1'b1); send(40, 1'b0); send(60, 1'b0);
        cfg_write(1, 0, 8192, 0);
        send(20, 1'b0); send(40, 1'b0); send(60, 1'b0);
        send(20, 1'b1); send(40, 1'b0); send(60, 1'b0);
        push_exp(20, 0, 1); push_exp(40, 1, 0); push_exp(60, 2, 0);
        push_exp(20, 0, 0); push_exp(40, 1, 0); push_exp(60, 2, 0);
        push_exp(20, 0, 1); push_exp(20, 1, 0); push_exp(60, 2, 0);
        check_all("shadow");

        // Shadow write coinciding with the SOF copy: copy sees the old value.
        in_data = 8'd50; in_sof = 1'b1; in_valid = 1'b1;
        cfg_ch = 2'd0; cfg_mean = 8'd0; cfg_scale = 16'd8192; cfg_zp = 8'd0; cfg_we = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; cfg_we = 1'b0;
        send(50, 1'b1);
        push_exp(50, 0, 1); push_exp(25, 0, 1);
        check_all("same_cyc");

        // One clipped beat, then reset mid-burst.
        send(255, 1'b1);
        push_exp(127, 0, 1);
        check_all("preclip");
        chk("preclip_sat_cnt", int'(sat_cnt), 1);
        fork
            begin
                for (int i = 0; i < 6; i++) send(30, (i == 0) ? 1'b1 : 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #3;
                rstn = 1'b0;
                #1;
                chk("rstmid_out_valid", int'(out_valid), 0);
                chk("rstmid_sat_cnt", int'(sat_cnt), 0);
                chk("rstmid_out_data", int'(out_data), 0);
            end
        join
        in_valid = 1'b0;
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        send(100, 1'b1); send(100, 1'b0);
        push_exp(100, 0, 1); push_exp(100, 1, 0);
        check_all("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
